mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Sequencing and arbitration controller for the shared N-bit combinational array multiplier in the arithmetic unit. It accepts multiply requests from two requesters over valid/ready handshakes and grants one requester at a time using round-robin priority. It registers the operands onto the multiplier inputs, waits a fixed settle window so the ripple array can be timed as a multicycle path, then captures the product and holds it on a valid/ready response port tagged with the requester ID.

## Interface
- N, 32, operand and product width; the product is the low N bits of A*B.
- SETTLE, 2, number of cycles the multiplier inputs are held stable before the product is sampled; legal range 1..15.

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous and active-high
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  N each  requester 0 operands
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  requester 1 pair accepted this cycle
- req1_a, req1_b  in  N each  requester 1 operands
- mul_a, mul_b  out  N each  registered multiplier operands (to multiplier A, B)
- mul_z  in  N  multiplier product (from multiplier Z)
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_z  out  N  captured product
- rsp_id  out  1  requester that issued the operation (0 or 1)
- busy  out  1  high whenever state is not IDLE

## Operation
- States:
  - IDLE: arbitrate and accept a request.
  - WAIT: count the settle window.
  - DONE: hold the response until it is accepted.
- Arbitration in IDLE:
  - Pointer rr selects the priority requester: 0 means requester 0 has priority.
  - If only one requester has valid high, grant it.
  - If both have valid high, grant the requester selected by rr.
  - reqX_ready is combinational: it is high only for the granted requester, and only in IDLE. Both readys are 0 outside IDLE.
- On acceptance (reqX_valid and reqX_ready):
  - Register the operands into mul_a and mul_b.
  - Latch the requester ID.
  - Set rr to the other requester.
  - Load the settle counter with SETTLE-1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reads 0, capture mul_z into rsp_z, set rsp_id, and go to DONE.
- DONE:
  - rsp_valid=1.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
  - No new request is accepted in the same cycle as the response is accepted.
- mul_a and mul_b change only on acceptance. They hold their value after completion.
- rsp_z and rsp_id hold their last value after acceptance; they are only meaningful while rsp_valid=1.
- Width rule: the product is truncated to N bits with no overflow indication. The block does no arithmetic of its own.
- A requester may drop valid before it sees ready. Nothing is captured in that case, and rr is unchanged.

## Timing
- Reset (synchronous): state IDLE, rr=0, counter 0. All outputs are 0: readys, mul_a, mul_b, rsp_valid, rsp_z, rsp_id, busy.
- Acceptance in cycle t:
  - mul_a and mul_b are valid from cycle t+1.
  - mul_z is sampled at the end of cycle t+SETTLE.
  - rsp_valid is high from cycle t+SETTLE+1.
- Minimum issue interval: SETTLE+2 cycles between successive acceptances when rsp_ready is tied high.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_z and rsp_id are stable and both readys stay 0.
- Reset asserted in any state, including mid-WAIT or DONE with rsp_valid=1:
  - The next state is IDLE with reset values.
  - The in-flight operation is discarded without a response.
- Simultaneous requests are serviced alternately: 0,1,0,1 while both stay valid.

## Test plan
- N=32, SETTLE=2, req0 a=6 b=7 accepted at cycle 0, rsp_ready=1 -> rsp_valid=1 at cycle 3 with rsp_z=42, rsp_id=0; busy=1 in cycles 1-3.
- Both valid continuously from reset, req0 3x5, req1 4x9 -> responses in order (15,id0), (36,id1), (15,id0); req1_ready never high in the same cycle as req0_ready.
- N=8, req1 a=20 b=20 -> rsp_z=144 (400 mod 256), rsp_id=1.
- rsp_ready held 0 for 5 cycles after rsp_valid rises, with req0_valid high throughout -> rsp_z and rsp_id stable, req0_ready=0 throughout; req0 is accepted the cycle after rsp_ready pulses.
- Reset pulsed one cycle during WAIT with SETTLE=4 -> next cycle busy=0, rsp_valid=0, mul_a=mul_b=0, and no response for the aborted operation.
- SETTLE=1, a=0xFFFFFFFF b=2 -> rsp_z=0xFFFFFFFE exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer for one shared combinational array multiplier.
// Operands are registered, held SETTLE cycles as a multicycle path, then the product is captured.
module mul_share_ctrl #(
  parameter int N      = 32,
  parameter int SETTLE = 2    // legal range 1..15 (counter is 4 bits)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  input  logic [N-1:0] mul_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_z,
  output logic         rsp_id,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Handshakes: a transfer occurs at a rising edge where valid and ready are both high;
  // valid may drop before ready is seen, and ready never depends on a registered valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic       rr;
  logic       op_id;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      op_id     <= 1'b0;
      cnt       <= 4'd0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            mul_a <= grant1 ? req1_a : req0_a;
            mul_b <= grant1 ? req1_b : req0_b;
            op_id <= grant1;
            rr    <= grant0;   // priority passes to the requester not just served
            cnt   <= 4'(SETTLE - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_z     <= mul_z;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: a cycle model with a product scoreboard on the main instance,
// plus directed checks on an 8-bit/SETTLE=4 instance and a SETTLE=1 instance.
module tb_mul_share_ctrl;
  localparam int SETTLE = 2;
  localparam int EW     = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- main instance: N=32, SETTLE=2 ----------------
  logic        a_rst, a_r0v, a_r0r, a_r1v, a_r1r, a_rv, a_rrdy, a_rid, a_busy;
  logic [31:0] a_r0a, a_r0b, a_r1a, a_r1b, a_ma, a_mb, a_mz, a_rz;
  logic [1:0]  a_dbg;

  mul_share_ctrl #(.N(32), .SETTLE(SETTLE)) u_a (
    .clk(clk), .reset(a_rst),
    .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_a(a_r0a), .req0_b(a_r0b),
    .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_a(a_r1a), .req1_b(a_r1b),
    .mul_a(a_ma), .mul_b(a_mb), .mul_z(a_mz),
    .rsp_valid(a_rv), .rsp_ready(a_rrdy), .rsp_z(a_rz), .rsp_id(a_rid),
    .busy(a_busy), .state_dbg(a_dbg)
  );

  // Slow multiplier: the product is wrong until the inputs have been stable SETTLE cycles.
  logic [31:0] pa = '0, pb = '0, true_prod;
  logic [4:0]  age = '0, stable;
  assign true_prod = a_ma * a_mb;
  assign stable = ((a_ma !== pa) || (a_mb !== pb)) ? 5'd1 :
                  ((age >= 5'd15) ? 5'd15 : age + 5'd1);
  assign a_mz = (stable >= 5'(SETTLE)) ? true_prod : ~true_prod;
  always @(posedge clk) begin
    pa  <= a_ma;
    pb  <= a_mb;
    age <= stable;
  end

  // Cycle model of the controller; products go through the expected queue.
  int          m_state = 0, m_cyc = 0, m_due = 0, m_acc = 0;
  logic        m_rr = 1'b0, m_on = 1'b0, g0, g1;
  logic [31:0] m_a = '0, m_b = '0, m_p;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] rsp_log[$];

  always @(negedge clk) begin
    #1;
    m_cyc++;
    if (a_rst) begin
      m_state = 0;
      m_rr    = 1'b0;
      m_a     = '0;
      m_b     = '0;
      exp_q.delete();
    end else if (m_on) begin
      g0 = (m_state == 0) && a_r0v && (!a_r1v || !m_rr);
      g1 = (m_state == 0) && a_r1v && (!a_r0v || m_rr);
      check_eq("req0_ready", 64'(a_r0r), 64'(g0));
      check_eq("req1_ready", 64'(a_r1r), 64'(g1));
      check_eq("busy", 64'(a_busy), 64'(m_state != 0));
      check_eq("rsp_valid", 64'(a_rv), 64'(m_state == 2));
      check_eq("mul_a", 64'(a_ma), 64'(m_a));
      check_eq("mul_b", 64'(a_mb), 64'(m_b));
      if (m_state == 2) begin
        check_eq("rsp_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check_eq("rsp_z", 64'(a_rz), 64'(exp_q[0][31:0]));
          check_eq("rsp_id", 64'(a_rid), 64'(exp_q[0][32]));
          if (a_rrdy) begin
            void'(exp_q.pop_front());
            rsp_log.push_back({a_rid, a_rz});
            m_state = 0;
          end
        end
      end else if (m_state == 1) begin
        if (m_cyc + 1 == m_due) m_state = 2;
      end else if (g0 || g1) begin
        m_a = g1 ? a_r1a : a_r0a;
        m_b = g1 ? a_r1b : a_r0b;
        m_p = m_a * m_b;
        exp_q.push_back({g1, m_p});
        m_rr    = g1 ? 1'b0 : 1'b1;
        m_due   = m_cyc + SETTLE + 1;
        m_state = 1;
        m_acc++;
      end
    end
  end

  task automatic wait_acc(input int target);
    int n = 0;
    while (m_acc < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_acc < target) check_eq("accept_timeout", 64'(m_acc), 64'(target));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_state != 0 || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("idle_timeout", 64'(m_state + exp_q.size()), 64'(0));
  endtask

  // ---------------- SETTLE=1 instance ----------------
  logic        b_rst, b_r0v, b_r0r, b_r1v, b_r1r, b_rv, b_rrdy, b_rid, b_busy;
  logic [31:0] b_r0a, b_r0b, b_r1a, b_r1b, b_ma, b_mb, b_mz, b_rz;
  logic [1:0]  b_dbg;
  assign b_mz = b_ma * b_mb;

  mul_share_ctrl #(.N(32), .SETTLE(1)) u_b (
    .clk(clk), .reset(b_rst),
    .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_a(b_r0a), .req0_b(b_r0b),
    .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_a(b_r1a), .req1_b(b_r1b),
    .mul_a(b_ma), .mul_b(b_mb), .mul_z(b_mz),
    .rsp_valid(b_rv), .rsp_ready(b_rrdy), .rsp_z(b_rz), .rsp_id(b_rid),
    .busy(b_busy), .state_dbg(b_dbg)
  );

  // ---------------- N=8, SETTLE=4 instance ----------------
  logic       c_rst, c_r0v, c_r0r, c_r1v, c_r1r, c_rv, c_rrdy, c_rid, c_busy;
  logic [7:0] c_r0a, c_r0b, c_r1a, c_r1b, c_ma, c_mb, c_mz, c_rz;
  logic [1:0] c_dbg;
  assign c_mz = c_ma * c_mb;

  mul_share_ctrl #(.N(8), .SETTLE(4)) u_c (
    .clk(clk), .reset(c_rst),
    .req0_valid(c_r0v), .req0_ready(c_r0r), .req0_a(c_r0a), .req0_b(c_r0b),
    .req1_valid(c_r1v), .req1_ready(c_r1r), .req1_a(c_r1a), .req1_b(c_r1b),
    .mul_a(c_ma), .mul_b(c_mb), .mul_z(c_mz),
    .rsp_valid(c_rv), .rsp_ready(c_rrdy), .rsp_z(c_rz), .rsp_id(c_rid),
    .busy(c_busy), .state_dbg(c_dbg)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_r0v = 1'b0; a_r1v = 1'b0; a_rrdy = 1'b1;
    a_r0a = '0; a_r0b = '0; a_r1a = '0; a_r1b = '0;
    b_r0v = 1'b0; b_r1v = 1'b0; b_rrdy = 1'b1;
    b_r0a = '0; b_r0b = '0; b_r1a = '0; b_r1b = '0;
    c_r0v = 1'b0; c_r1v = 1'b0; c_rrdy = 1'b1;
    c_r0a = '0; c_r0b = '0; c_r1a = '0; c_r1b = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy", 64'(a_busy), 64'(0));
    check_eq("rst_rsp_valid", 64'(a_rv), 64'(0));
    check_eq("rst_rsp_z", 64'(a_rz), 64'(0));
    check_eq("rst_rsp_id", 64'(a_rid), 64'(0));
    check_eq("rst_mul_a", 64'(a_ma), 64'(0));
    check_eq("rst_mul_b", 64'(a_mb), 64'(0));
    check_eq("rst_ready0", 64'(a_r0r), 64'(0));
    check_eq("rst_ready1", 64'(a_r1r), 64'(0));
    check_eq("rst_state", 64'(a_dbg), 64'(0));

    // Both requesters valid straight out of reset: expect 0,1,0.
    @(negedge clk);
    a_rst = 1'b0;
    m_on  = 1'b1;
    a_r0v = 1'b1; a_r0a = 32'd3; a_r0b = 32'd5;
    a_r1v = 1'b1; a_r1a = 32'd4; a_r1b = 32'd9;
    wait_acc(3);
    a_r0v = 1'b0; a_r1v = 1'b0;
    wait_idle();
    check_eq("alt_count", 64'(rsp_log.size()), 64'(3));
    if (rsp_log.size() >= 3) begin
      check_eq("alt_rsp0", 64'(rsp_log[0]), 64'({1'b0, 32'd15}));
      check_eq("alt_rsp1", 64'(rsp_log[1]), 64'({1'b1, 32'd36}));
      check_eq("alt_rsp2", 64'(rsp_log[2]), 64'({1'b0, 32'd15}));
    end

    // Single request 6x7.
    a_r0v = 1'b1; a_r0a = 32'd6; a_r0b = 32'd7;
    wait_acc(4);
    a_r0v = 1'b0;
    wait_idle();
    check_eq("single_count", 64'(rsp_log.size()), 64'(4));
    if (rsp_log.size() >= 4) check_eq("single_rsp", 64'(rsp_log[3]), 64'({1'b0, 32'd42}));

    // Backpressure: response held 5 cycles while req0 keeps asking.
    a_rrdy = 1'b0;
    a_r0v = 1'b1; a_r0a = 32'd11; a_r0b = 32'd13;
    wait_acc(5);
    a_r0a = 32'd2; a_r0b = 32'd3;
    for (int n = 0; n < 50 && m_state != 2; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    a_rrdy = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp_accept_next", 64'(a_r0r), 64'(1));
    @(negedge clk);
    a_r0v = 1'b0;
    wait_idle();
    check_eq("bp_count", 64'(rsp_log.size()), 64'(6));
    if (rsp_log.size() >= 6) check_eq("bp_rsp", 64'(rsp_log[4]), 64'({1'b0, 32'd143}));

    // Random traffic, including valid withdrawn before acceptance.
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      a_r0v  = 1'($urandom_range(0, 1));
      a_r1v  = 1'($urandom_range(0, 1));
      a_r0a  = $urandom(); a_r0b = $urandom();
      a_r1a  = $urandom(); a_r1b = $urandom();
      a_rrdy = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    a_r0v = 1'b0; a_r1v = 1'b0; a_rrdy = 1'b1;
    wait_idle();

    // SETTLE=1: product of 0xFFFFFFFF*2 valid two cycles after acceptance.
    @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    b_r0v = 1'b1; b_r0a = 32'hFFFF_FFFF; b_r0b = 32'd2;
    #1;
    check_eq("s1_accept", 64'(b_r0r), 64'(1));
    @(negedge clk);
    b_r0v = 1'b0;
    #1;
    check_eq("s1_wait_valid", 64'(b_rv), 64'(0));
    check_eq("s1_wait_busy", 64'(b_busy), 64'(1));
    check_eq("s1_mul_a", 64'(b_ma), 64'(32'hFFFF_FFFF));
    @(negedge clk);
    #1;
    check_eq("s1_rsp_valid", 64'(b_rv), 64'(1));
    check_eq("s1_rsp_z", 64'(b_rz), 64'(32'hFFFF_FFFE));
    check_eq("s1_rsp_id", 64'(b_rid), 64'(0));
    @(negedge clk);
    #1;
    check_eq("s1_idle", 64'(b_busy), 64'(0));

    // N=8, SETTLE=4: 20*20 truncates to 144, from requester 1.
    @(negedge clk);
    c_rst = 1'b0;
    @(negedge clk);
    c_r1v = 1'b1; c_r1a = 8'd20; c_r1b = 8'd20;
    #1;
    check_eq("n8_accept", 64'(c_r1r), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      c_r1v = 1'b0;
      #1;
      check_eq("n8_wait_valid", 64'(c_rv), 64'(0));
    end
    @(negedge clk);
    #1;
    check_eq("n8_rsp_valid", 64'(c_rv), 64'(1));
    check_eq("n8_rsp_z", 64'(c_rz), 64'(144));
    check_eq("n8_rsp_id", 64'(c_rid), 64'(1));
    @(negedge clk);
    #1;
    check_eq("n8_idle", 64'(c_busy), 64'(0));

    // Reset pulse during WAIT aborts the operation.
    @(negedge clk);
    c_r0v = 1'b1; c_r0a = 8'd3; c_r0b = 8'd3;
    #1;
    check_eq("abort_accept", 64'(c_r0r), 64'(1));
    @(negedge clk);
    c_r0v = 1'b0;
    @(negedge clk);
    c_rst = 1'b1;
    #1;
    check_eq("abort_in_wait", 64'(c_busy), 64'(1));
    @(negedge clk);
    c_rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(c_busy), 64'(0));
    check_eq("abort_rsp_valid", 64'(c_rv), 64'(0));
    check_eq("abort_mul_a", 64'(c_ma), 64'(0));
    check_eq("abort_mul_b", 64'(c_mb), 64'(0));
    check_eq("abort_rsp_z", 64'(c_rz), 64'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check_eq("abort_no_rsp", 64'(c_rv), 64'(0));
    end

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
